// File: rtl/cbfp_index_gen.sv
// Block-floating-point index generator: finds the per-group minimum redundant-sign-bit
// count for re and im, then replays each buffered group time-aligned with its index.
module cbfp_index_gen #(
    parameter int IN_W    = 16,
    parameter int SHIFT_W = 5,
    parameter int LANES   = 16,
    parameter int GRP_CYC = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_in,
    input  logic [LANES-1:0][IN_W-1:0]      data_re_in,
    input  logic [LANES-1:0][IN_W-1:0]      data_im_in,
    output logic                            valid_out,
    output logic [LANES-1:0][IN_W-1:0]      data_re_out,
    output logic [LANES-1:0][IN_W-1:0]      data_im_out,
    output logic [LANES-1:0][SHIFT_W-1:0]   index1_re_out,
    output logic [LANES-1:0][SHIFT_W-1:0]   index1_im_out,
    output logic                            grp_last_out
);

    localparam int                 CNT_W    = (GRP_CYC > 1) ? $clog2(GRP_CYC) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(GRP_CYC - 1);
    localparam logic [SHIFT_W-1:0] MAX_LSC  = SHIFT_W'(IN_W - 1);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t                         r_state, w_stateNext;
    logic                           r_wrBank, r_rdBank, w_rdBankNext;
    logic [CNT_W-1:0]               r_wrCnt, r_rdCnt, w_rdCntNext, w_emitCnt;
    logic [1:0]                     r_full, w_fullEff, w_fullNext;
    logic [SHIFT_W-1:0]             r_minRe, r_minIm, w_minRe, w_minIm;
    logic [SHIFT_W-1:0]             r_idxRe [2];
    logic [SHIFT_W-1:0]             r_idxIm [2];
    logic [SHIFT_W-1:0]             w_grpIdxRe, w_grpIdxIm;
    logic [LANES-1:0][IN_W-1:0]     r_memRe [2][GRP_CYC];
    logic [LANES-1:0][IN_W-1:0]     r_memIm [2][GRP_CYC];
    logic                           w_wrDone, w_emit, w_emitLast;

    function automatic logic [SHIFT_W-1:0] lsc(input logic [IN_W-1:0] x);
        logic [SHIFT_W-1:0] n;
        logic               run;
        n   = '0;
        run = 1'b1;
        for (int b = IN_W - 2; b >= 0; b--) begin
            if (run && (x[b] == x[IN_W-1])) n = n + 1'b1;
            else                            run = 1'b0;
        end
        return n;
    endfunction

    always_comb begin
        w_minRe = r_minRe;
        w_minIm = r_minIm;
        for (int l = 0; l < LANES; l++) begin
            if (lsc(data_re_in[l]) < w_minRe) w_minRe = lsc(data_re_in[l]);
            if (lsc(data_im_in[l]) < w_minIm) w_minIm = lsc(data_im_in[l]);
        end
    end

    // A bank completing on this edge counts as full so its drain can start on the same edge.
    always_comb begin
        w_wrDone  = valid_in && (r_wrCnt == LAST_CNT);
        w_fullEff = r_full;
        if (w_wrDone) w_fullEff[r_wrBank] = 1'b1;
    end

    always_comb begin
        w_stateNext  = r_state;
        w_rdCntNext  = r_rdCnt;
        w_rdBankNext = r_rdBank;
        w_emit       = 1'b0;
        w_emitLast   = 1'b0;
        w_emitCnt    = (r_state == S_DRAIN) ? r_rdCnt : '0;
        case (r_state)
            S_IDLE:  w_emit = w_fullEff[r_rdBank];
            S_DRAIN: w_emit = 1'b1;
            default: w_emit = 1'b0;
        endcase
        if (w_emit) begin
            w_emitLast = (w_emitCnt == LAST_CNT);
            if (w_emitLast) begin
                w_rdCntNext  = '0;
                w_rdBankNext = ~r_rdBank;
                w_stateNext  = w_fullEff[~r_rdBank] ? S_DRAIN : S_IDLE;
            end else begin
                w_rdCntNext  = w_emitCnt + 1'b1;
                w_stateNext  = S_DRAIN;
            end
        end
        w_fullNext = r_full;
        if (w_emit && w_emitLast) w_fullNext[r_rdBank] = 1'b0;
        if (w_wrDone)             w_fullNext[r_wrBank] = 1'b1;
        w_grpIdxRe = r_full[r_rdBank] ? r_idxRe[r_rdBank] : w_minRe;
        w_grpIdxIm = r_full[r_rdBank] ? r_idxIm[r_rdBank] : w_minIm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rdCnt  <= '0;
            r_rdBank <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_rdCnt  <= w_rdCntNext;
            r_rdBank <= w_rdBankNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrBank   <= 1'b0;
            r_wrCnt    <= '0;
            r_full     <= '0;
            r_minRe    <= MAX_LSC;
            r_minIm    <= MAX_LSC;
            r_idxRe[0] <= '0;
            r_idxRe[1] <= '0;
            r_idxIm[0] <= '0;
            r_idxIm[1] <= '0;
        end else begin
            r_full <= w_fullNext;
            if (valid_in) begin
                if (w_wrDone) begin
                    r_wrCnt           <= '0;
                    r_wrBank          <= ~r_wrBank;
                    r_minRe           <= MAX_LSC;
                    r_minIm           <= MAX_LSC;
                    r_idxRe[r_wrBank] <= w_minRe;
                    r_idxIm[r_wrBank] <= w_minIm;
                end else begin
                    r_wrCnt <= r_wrCnt + 1'b1;
                    r_minRe <= w_minRe;
                    r_minIm <= w_minIm;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_memRe[r_wrBank][r_wrCnt] <= data_re_in;
            r_memIm[r_wrBank][r_wrCnt] <= data_im_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out     <= 1'b0;
            grp_last_out  <= 1'b0;
            data_re_out   <= '0;
            data_im_out   <= '0;
            index1_re_out <= '0;
            index1_im_out <= '0;
        end else begin
            valid_out    <= w_emit;
            grp_last_out <= w_emit && w_emitLast;
            if (w_emit) begin
                data_re_out   <= r_memRe[r_rdBank][w_emitCnt];
                data_im_out   <= r_memIm[r_rdBank][w_emitCnt];
                index1_re_out <= {LANES{w_grpIdxRe}};
                index1_im_out <= {LANES{w_grpIdxIm}};
            end
        end
    end

    // Writing into a bank that has not yet been drained would corrupt a pending group.
    a_noOverflow: assert property (@(posedge clk) disable iff (rst) valid_in |-> !r_full[r_wrBank]);

endmodule

// File: tb/tb_cbfp_index_gen.sv
// Self-checking bench for cbfp_index_gen: table-driven groups with hand-computed indices,
// plus continuous, gapped and mid-group-reset sequences checked against an arrival-time rule.
module tb_cbfp_index_gen;

    localparam int IN_W    = 16;
    localparam int SHIFT_W = 5;
    localparam int LANES   = 16;
    localparam int GRP_CYC = 4;

    typedef logic [LANES-1:0][IN_W-1:0]    beat_t;
    typedef logic [LANES-1:0][SHIFT_W-1:0] idxv_t;

    typedef struct {
        string              name;
        logic [IN_W-1:0]    reFill;
        logic [IN_W-1:0]    imFill;
        bit                 ramp;
        int                 spBeat;
        int                 spLane;
        logic [IN_W-1:0]    spVal;
        logic [SHIFT_W-1:0] xRe;
        logic [SHIFT_W-1:0] xIm;
    } vec_t;

    typedef struct {
        beat_t              re;
        beat_t              im;
        logic [SHIFT_W-1:0] xRe;
        logic [SHIFT_W-1:0] xIm;
        logic               last;
        int                 cyc;
    } exp_t;

    typedef struct {
        beat_t re;
        beat_t im;
        idxv_t iRe;
        idxv_t iIm;
        logic  last;
        int    cyc;
    } obs_t;

    logic  clk, rst, valid_in, valid_out, grp_last_out;
    beat_t data_re_in, data_im_in, data_re_out, data_im_out;
    idxv_t index1_re_out, index1_im_out;

    int    nChecks = 0;
    int    nFails  = 0;
    int    cycCnt  = 0;
    int    lastInCyc;
    exp_t  expQ[$];
    obs_t  obsQ[$];
    beat_t grpRe[GRP_CYC];
    beat_t grpIm[GRP_CYC];
    vec_t  vecs[6];

    cbfp_index_gen #(.IN_W(IN_W), .SHIFT_W(SHIFT_W), .LANES(LANES), .GRP_CYC(GRP_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .data_re_in    (data_re_in),
        .data_im_in    (data_im_in),
        .valid_out     (valid_out),
        .data_re_out   (data_re_out),
        .data_im_out   (data_im_out),
        .index1_re_out (index1_re_out),
        .index1_im_out (index1_im_out),
        .grp_last_out  (grp_last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycCnt++;

    always @(negedge clk) begin
        obs_t o;
        if (!rst && valid_out) begin
            o.re   = data_re_out;
            o.im   = data_im_out;
            o.iRe  = index1_re_out;
            o.iIm  = index1_im_out;
            o.last = grp_last_out;
            o.cyc  = cycCnt;
            obsQ.push_back(o);
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic v, input beat_t re, input beat_t im);
        @(negedge clk);
        valid_in   = v;
        data_re_in = re;
        data_im_in = im;
        lastInCyc  = cycCnt;
    endtask

    task automatic fillGroup(input logic [IN_W-1:0] reVal, input logic [IN_W-1:0] imVal);
        for (int b = 0; b < GRP_CYC; b++) begin
            for (int l = 0; l < LANES; l++) begin
                grpRe[b][l] = reVal;
                grpIm[b][l] = imVal;
            end
        end
    endtask

    // Beat k of a group must appear one cycle after its final input beat was accepted, plus k.
    task automatic sendGroup(input logic [SHIFT_W-1:0] xRe, input logic [SHIFT_W-1:0] xIm, input int gap);
        exp_t e;
        for (int k = 0; k < GRP_CYC; k++) begin
            applyStimulus(1'b1, grpRe[k], grpIm[k]);
            if (k < GRP_CYC - 1)
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, '0, '0);
        end
        for (int k = 0; k < GRP_CYC; k++) begin
            e.re   = grpRe[k];
            e.im   = grpIm[k];
            e.xRe  = xRe;
            e.xIm  = xIm;
            e.last = (k == GRP_CYC - 1);
            e.cyc  = lastInCyc + 1 + k;
            expQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name);
        int    waited;
        int    n;
        idxv_t want;
        applyStimulus(1'b0, '0, '0);
        waited = 0;
        while (obsQ.size() < expQ.size() && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        repeat (GRP_CYC + 2) @(negedge clk);
        check({name, " beat count"}, 256'(obsQ.size()), 256'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s b%0d re", name, i), obsQ[i].re, expQ[i].re);
            check($sformatf("%s b%0d im", name, i), obsQ[i].im, expQ[i].im);
            want = {LANES{expQ[i].xRe}};
            check($sformatf("%s b%0d idxRe", name, i), obsQ[i].iRe, want);
            want = {LANES{expQ[i].xIm}};
            check($sformatf("%s b%0d idxIm", name, i), obsQ[i].iIm, want);
            check($sformatf("%s b%0d last", name, i), 256'(obsQ[i].last), 256'(expQ[i].last));
            check($sformatf("%s b%0d cycle", name, i), 256'(obsQ[i].cyc), 256'(expQ[i].cyc));
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic checkZeroOutputs(input string name);
        check({name, " valid"}, 256'(valid_out), 256'(0));
        check({name, " last"}, 256'(grp_last_out), 256'(0));
        check({name, " re"}, data_re_out, 256'(0));
        check({name, " im"}, data_im_out, 256'(0));
        check({name, " idxRe"}, index1_re_out, 256'(0));
        check({name, " idxIm"}, index1_im_out, 256'(0));
    endtask

    task automatic setVec(input int i, input string name, input logic [IN_W-1:0] reFill,
                          input logic [IN_W-1:0] imFill, input bit ramp, input int spBeat,
                          input int spLane, input logic [IN_W-1:0] spVal,
                          input logic [SHIFT_W-1:0] xRe, input logic [SHIFT_W-1:0] xIm);
        vecs[i].name   = name;
        vecs[i].reFill = reFill;
        vecs[i].imFill = imFill;
        vecs[i].ramp   = ramp;
        vecs[i].spBeat = spBeat;
        vecs[i].spLane = spLane;
        vecs[i].spVal  = spVal;
        vecs[i].xRe    = xRe;
        vecs[i].xIm    = xIm;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst        = 1'b1;
        valid_in   = 1'b0;
        data_re_in = '0;
        data_im_in = '0;

        setVec(0, "zeros",      16'h0000, 16'h0000, 1'b0, -1, 0,  16'h0000, 5'd15, 5'd15);
        setVec(1, "threes",     16'h0003, 16'h0003, 1'b0,  2, 5,  16'h4000, 5'd0,  5'd13);
        setVec(2, "ramp",       16'h0000, 16'h0000, 1'b1, -1, 0,  16'h0000, 5'd9,  5'd9);
        setVec(3, "minNeg",     16'h8000, 16'hFFFF, 1'b0, -1, 0,  16'h0000, 5'd0,  5'd15);
        setVec(4, "mixed",      16'h1FFF, 16'hC000, 1'b0, -1, 0,  16'h0000, 5'd2,  5'd1);
        setVec(5, "lastBeatSp", 16'h0001, 16'hFFFE, 1'b0,  3, 15, 16'h0400, 5'd4,  5'd14);

        repeat (3) @(negedge clk);
        checkZeroOutputs("reset");
        rst = 1'b0;
        @(negedge clk);
        checkZeroOutputs("after reset");

        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < GRP_CYC; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (vecs[v].ramp) begin
                        grpRe[b][l] = 16'(b * 16 + l);
                        grpIm[b][l] = ~16'(b * 16 + l);
                    end else begin
                        grpRe[b][l] = vecs[v].reFill;
                        grpIm[b][l] = vecs[v].imFill;
                    end
                    if (b == vecs[v].spBeat && l == vecs[v].spLane) grpRe[b][l] = vecs[v].spVal;
                end
            end
            sendGroup(vecs[v].xRe, vecs[v].xIm, 0);
            checkOutput(vecs[v].name);
        end

        fillGroup(16'h1FFF, 16'h1FFF);
        sendGroup(5'd2, 5'd2, 0);
        fillGroup(16'hC000, 16'hC000);
        sendGroup(5'd1, 5'd1, 0);
        fillGroup(16'h0001, 16'h0001);
        sendGroup(5'd14, 5'd14, 0);
        checkOutput("continuous");

        fillGroup(16'h0200, 16'hFC00);
        sendGroup(5'd5, 5'd5, 2);
        checkOutput("gapped");

        fillGroup(16'h4000, 16'h4000);
        applyStimulus(1'b1, grpRe[0], grpIm[0]);
        applyStimulus(1'b1, grpRe[1], grpIm[1]);
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        checkZeroOutputs("mid reset");
        rst = 1'b0;
        fillGroup(16'h00FF, 16'hFF00);
        sendGroup(5'd7, 5'd7, 0);
        checkOutput("after mid reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
